// File: rtl/sd_regs_pkg.sv
// Shared definitions for the SD host configuration register bank:
// register byte offsets, access types, phase FSM states and req codes.
package sd_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;

    localparam logic [ADDR_W-1:0] OFF_CTRL    = 8'h00;
    localparam logic [ADDR_W-1:0] OFF_STATUS  = 8'h04;
    localparam logic [ADDR_W-1:0] OFF_IRQ_EN  = 8'h08;
    localparam logic [ADDR_W-1:0] OFF_ID      = 8'h0C;
    localparam logic [ADDR_W-1:0] OFF_ACC_CNT = 8'h10;
    localparam logic [ADDR_W-1:0] OFF_SCRATCH = 8'h14;

    localparam logic [1:0] REQ_IDLE    = 2'b00;
    localparam logic [1:0] REQ_SETUP   = 2'b01;
    localparam logic [1:0] REQ_ILLEGAL = 2'b10;
    localparam logic [1:0] REQ_ACCESS  = 2'b11;

    typedef enum logic [1:0] {
        ACC_RW,
        ACC_RO,
        ACC_W1C
    } acc_type_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } phase_e;

    // Access type of an (already validated) aligned byte address.
    function automatic acc_type_e acc_type(input logic [ADDR_W-1:0] addr);
        case (addr)
            OFF_STATUS:          return ACC_W1C;
            OFF_ID, OFF_ACC_CNT: return ACC_RO;
            default:             return ACC_RW;
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_phase_fsm.sv
// Phase tracker for the configuration bus initiator.
// Ports: clk, reset (async active-low), req (phase code), addr_valid
// (current address decodes to an implemented word), access_en (accept an
// access this edge), phase_err (illegal phase or illegal access this edge).
module reg_bank_phase_fsm
    import sd_regs_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       addr_valid,
    output logic       access_en,
    output logic       phase_err
);

    phase_e state_q;
    phase_e state_d;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The destination depends only on req: setup is optional and any phase
    // may be entered from any other, so the current state only sets the default.
    always_comb begin
        state_d   = state_q;
        access_en = 1'b0;
        phase_err = 1'b0;
        case (req)
            REQ_IDLE:    state_d = PH_IDLE;
            REQ_SETUP:   state_d = PH_SETUP;
            REQ_ACCESS: begin
                state_d   = PH_ACCESS;
                access_en = addr_valid;
                phase_err = !addr_valid;
            end
            default: begin
                state_d   = PH_IDLE;
                phase_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reg_bank_responder.sv
// Target-side register bank for the SD host configuration bus.
// Ports: clk, reset (async active-low), req/wnr/address/data_in (initiator
// request), status_set (hardware event pulses into STATUS), data_out/ack/err
// (registered response), ctrl_out (CTRL register), irq (|(STATUS & IRQ_EN)).
module reg_bank_responder
    import sd_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS = 64,
    parameter logic [31:0] ID_VALUE = 32'h005D_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic              wnr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] status_set,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] ctrl_out,
    output logic              irq
);

    localparam logic [6:0] NUM_REGS_W = 7'(NUM_REGS);

    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] irq_en_q, irq_en_d;
    logic [DATA_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] scratch_q [NUM_REGS];
    logic              ack_q, err_q, irq_q;

    logic              addr_valid;
    logic              access_en;
    logic              phase_err;
    logic              scratch_we;
    logic [DATA_W-1:0] w1c_mask;
    logic [DATA_W-1:0] rdata;

    assign addr_valid = (address[1:0] == 2'b00) && ({1'b0, address[7:2]} < NUM_REGS_W);

    reg_bank_phase_fsm u_fsm (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .addr_valid (addr_valid),
        .access_en  (access_en),
        .phase_err  (phase_err)
    );

    // Read mux: value of the addressed register before the current edge.
    always_comb begin
        case (address)
            OFF_CTRL:    rdata = ctrl_q;
            OFF_STATUS:  rdata = status_q;
            OFF_IRQ_EN:  rdata = irq_en_q;
            OFF_ID:      rdata = ID_VALUE;
            OFF_ACC_CNT: rdata = acc_cnt_q;
            default:     rdata = scratch_q[address[7:2]];
        endcase
    end

    // Next-state for the named registers and the read-data register.
    always_comb begin
        ctrl_d     = ctrl_q;
        irq_en_d   = irq_en_q;
        w1c_mask   = '0;
        data_out_d = data_out_q;
        scratch_we = 1'b0;
        acc_cnt_d  = acc_cnt_q + 32'(access_en);
        if (access_en) begin
            if (!wnr) begin
                data_out_d = rdata;
            end else begin
                case (acc_type(address))
                    ACC_W1C: w1c_mask = data_in;
                    ACC_RW: begin
                        if (address == OFF_CTRL) begin
                            ctrl_d = data_in;
                        end else if (address == OFF_IRQ_EN) begin
                            irq_en_d = data_in;
                        end else begin
                            scratch_we = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // Hardware set is applied after the clear so a same-edge set wins.
        status_d = (status_q & ~w1c_mask) | status_set;
    end

    // Control/status registers and the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            acc_cnt_q  <= '0;
            data_out_q <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            status_q   <= status_d;
            irq_en_q   <= irq_en_d;
            acc_cnt_q  <= acc_cnt_d;
            data_out_q <= data_out_d;
            ack_q      <= access_en;
            err_q      <= phase_err;
            irq_q      <= |(status_q & irq_en_q);
        end
    end

    // Scratch words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                scratch_q[i] <= '0;
            end
        end else if (scratch_we) begin
            scratch_q[address[7:2]] <= data_in;
        end
    end

    assign data_out = data_out_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_reg_bank_responder.sv
// Bench for reg_bank_responder: a word-array model of the register map,
// checked against the DUT every falling edge, plus directed literal checks.
module tb_reg_bank_responder;
    import sd_regs_pkg::*;

    localparam int unsigned NUM_REGS = 64;
    localparam logic [31:0] ID_VALUE = 32'h005D_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req;
    logic        wnr;
    logic [7:0]  address;
    logic [31:0] data_in;
    logic [31:0] status_set;
    logic [31:0] data_out;
    logic        ack;
    logic        err;
    logic [31:0] ctrl_out;
    logic        irq;

    always #5 clk = ~clk;

    reg_bank_responder #(.NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (req),
        .wnr        (wnr),
        .address    (address),
        .data_in    (data_in),
        .status_set (status_set),
        .data_out   (data_out),
        .ack        (ack),
        .err        (err),
        .ctrl_out   (ctrl_out),
        .irq        (irq)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: words indexed by address/4; index 3 is ID, 4 is ACC_CNT (kept in m_acc).
    logic [31:0] m_regs [64];
    logic [31:0] m_acc;
    logic [31:0] m_dout;
    logic        m_ack, m_err, m_irq;

    task automatic model_step();
        logic [31:0] old_status, old_en, clr;
        int idx;
        bit valid;
        old_status = m_regs[1];
        old_en     = m_regs[2];
        clr        = 32'h0;
        idx        = int'(address) / 4;
        valid      = (int'(address) % 4 == 0) && (idx < int'(NUM_REGS));
        m_ack      = 1'b0;
        m_err      = 1'b0;
        if (req == 2'b10) begin
            m_err = 1'b1;
        end else if (req == 2'b11) begin
            if (!valid) begin
                m_err = 1'b1;
            end else begin
                m_ack = 1'b1;
                if (!wnr) begin
                    if (idx == 3)      m_dout = ID_VALUE;
                    else if (idx == 4) m_dout = m_acc;
                    else               m_dout = m_regs[idx];
                end else if (idx == 1) begin
                    clr = data_in;
                end else if (idx != 3 && idx != 4) begin
                    m_regs[idx] = data_in;
                end
                m_acc = m_acc + 32'd1;
            end
        end
        m_regs[1] = (old_status & ~clr) | status_set;
        m_irq     = |(old_status & old_en);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_regs[i] = 32'h0;
            m_acc  = 32'h0;
            m_dout = 32'h0;
            m_ack  = 1'b0;
            m_err  = 1'b0;
            m_irq  = 1'b0;
        end else begin
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc data_out", data_out, m_dout);
            check("cyc ack", 32'(ack), 32'(m_ack));
            check("cyc err", 32'(err), 32'(m_err));
            check("cyc ctrl_out", ctrl_out, m_regs[0]);
            check("cyc irq", 32'(irq), 32'(m_irq));
            check("cyc ack_err_excl", 32'(ack & err), 32'h0);
        end
    end

    task automatic cyc(input logic [1:0] r, input logic w, input logic [7:0] a,
                       input logic [31:0] d, input logic [31:0] s);
        @(negedge clk);
        req        = r;
        wnr        = w;
        address    = a;
        data_in    = d;
        status_set = s;
    endtask

    initial begin
        logic [31:0] v, pv, first_v;
        req = 2'b00; wnr = 1'b0; address = 8'h00; data_in = 32'h0; status_set = 32'h0;
        pv = 32'h0;
        first_v = 32'h0;

        // Reset state.
        #10;
        check("rst data_out", data_out, 32'h0);
        check("rst ack", 32'(ack), 32'h0);
        check("rst err", 32'(err), 32'h0);
        check("rst ctrl_out", ctrl_out, 32'h0);
        check("rst irq", 32'(irq), 32'h0);
        #5;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ID read straight from idle.
        cyc(2'b11, 1'b0, 8'h0C, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("id read data", data_out, 32'h005D_0001);
        check("id read ack", 32'(ack), 32'h1);
        check("id read err", 32'(err), 32'h0);

        // Stream of write/read pairs with req held at 11.
        for (int a = 8'h14; a <= 8'hFC; a += 4) begin
            v = $urandom;
            if (a == 8'h14) first_v = v;
            cyc(2'b11, 1'b1, 8'(a), v, 32'h0);
            if (a != 8'h14) check("stream readback", data_out, pv);
            cyc(2'b11, 1'b0, 8'(a), 32'h0, 32'h0);
            pv = v;
        end
        cyc(2'b11, 1'b0, 8'h10, 32'h0, 32'h0);
        check("stream last readback", data_out, pv);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("acc_cnt after stream", data_out, 32'd119);

        // W1C against a same-edge hardware set.
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h3);
        cyc(2'b11, 1'b1, 8'h04, 32'h3, 32'h1);
        cyc(2'b11, 1'b0, 8'h04, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("status set wins", data_out, 32'h1);

        // Enable the pending bit; irq follows one cycle later.
        cyc(2'b11, 1'b1, 8'h08, 32'h1, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("irq not yet", 32'(irq), 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("irq raised", 32'(irq), 32'h1);

        // Unaligned address: err, no write.
        cyc(2'b11, 1'b1, 8'h15, 32'hDEAD_BEEF, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("unaligned err", 32'(err), 32'h1);
        check("unaligned ack", 32'(ack), 32'h0);
        cyc(2'b11, 1'b0, 8'h14, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("unaligned no write", data_out, first_v);

        // Write to read-only ID.
        cyc(2'b11, 1'b1, 8'h0C, 32'hFFFF_FFFF, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("ro write ack", 32'(ack), 32'h1);
        check("ro write err", 32'(err), 32'h0);
        cyc(2'b11, 1'b0, 8'h0C, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("id unchanged", data_out, 32'h005D_0001);

        // Illegal phase code.
        cyc(2'b10, 1'b0, 8'h00, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("req10 err", 32'(err), 32'h1);
        check("req10 ack", 32'(ack), 32'h0);
        check("req10 fsm idle", 32'(dut.u_fsm.state_q), 32'(PH_IDLE));

        // Reset asserted mid-stream.
        cyc(2'b11, 1'b1, 8'h00, 32'hA5A5_0001, 32'h0);
        cyc(2'b11, 1'b1, 8'h18, 32'h0000_1234, 32'h0);
        check("ctrl before reset", ctrl_out, 32'hA5A5_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst ctrl_out", ctrl_out, 32'h0);
        check("async rst ack", 32'(ack), 32'h0);
        check("async rst data_out", data_out, 32'h0);
        check("async rst irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 2'b00;
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("post rst ack", 32'(ack), 32'h0);
        check("post rst ctrl_out", ctrl_out, 32'h0);

        // ACC_CNT wrap.
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        force dut.acc_cnt_q = 32'hFFFF_FFFF;
        m_acc = 32'hFFFF_FFFF;
        #1;
        release dut.acc_cnt_q;
        cyc(2'b11, 1'b1, 8'h20, 32'h0000_0007, 32'h0);
        cyc(2'b11, 1'b0, 8'h10, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        check("acc_cnt wrap", data_out, 32'h0);

        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        cyc(2'b00, 1'b0, 8'h00, 32'h0, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
